// File: rtl/half_adder_behavior.sv
`default_nettype none
// ============================================================================
//  Module   : half_adder_behavior
//  Brief    : WIDTH-lane half adder with combinational s/c, a registered
//             valid-qualified copy and a saturating carry-event counter.
//  Revision : 1.0
// ============================================================================
module half_adder_behavior #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     s,
  output logic [WIDTH-1:0]     c,
  output logic [WIDTH-1:0]     s_q,
  output logic [WIDTH-1:0]     c_q,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] carry_cnt,
  input  logic                 clr_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_carry;
  logic                 w_any_carry;
  logic                 w_cnt_inc;

  logic [WIDTH-1:0]     r_s_q;
  logic [WIDTH-1:0]     r_c_q;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_carry_cnt;

  // Lanes are fully independent; no carry propagates between them.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      assign w_sum[i]   = a[i] ^ b[i];
      assign w_carry[i] = a[i] & b[i];
    end
  endgenerate

  assign w_any_carry = |w_carry;
  assign w_cnt_inc   = in_valid && w_any_carry && (r_carry_cnt != c_cnt_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q       <= '0;
      r_c_q       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s_q <= w_sum;
        r_c_q <= w_carry;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (clr_cnt) begin
      r_carry_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_carry_cnt <= r_carry_cnt + c_cnt_one;
    end
  end

  assign s         = w_sum;
  assign c         = w_carry;
  assign s_q       = r_s_q;
  assign c_q       = r_c_q;
  assign out_valid = r_out_valid;
  assign carry_cnt = r_carry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_half_adder_behavior.sv
`default_nettype none
// ============================================================================
//  Module   : tb_half_adder_behavior
//  Brief    : Directed and random self-checking bench for half_adder_behavior
//             across WIDTH=1, WIDTH=4/CNT_WIDTH=2 and WIDTH=8 instances.
//  Revision : 1.0
// ============================================================================
module tb_half_adder_behavior;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // WIDTH=1 instance
  logic       a1, b1, iv1, clr1;
  logic       s1, c1, sq1, cq1, ov1;
  logic [15:0] cnt1;
  // WIDTH=4, CNT_WIDTH=2 instance
  logic [3:0] a4, b4, s4, c4, sq4, cq4;
  logic       iv4, clr4, ov4;
  logic [1:0] cnt4;
  // WIDTH=8 instance
  logic [7:0] a8, b8, s8, c8, sq8, cq8;
  logic       iv8, clr8, ov8;
  logic [15:0] cnt8;

  half_adder_behavior #(.WIDTH(1), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .s(s1), .c(c1), .s_q(sq1), .c_q(cq1), .out_valid(ov1),
    .carry_cnt(cnt1), .clr_cnt(clr1)
  );

  half_adder_behavior #(.WIDTH(4), .CNT_WIDTH(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4),
    .s(s4), .c(c4), .s_q(sq4), .c_q(cq4), .out_valid(ov4),
    .carry_cnt(cnt4), .clr_cnt(clr4)
  );

  half_adder_behavior #(.WIDTH(8), .CNT_WIDTH(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
    .s(s8), .c(c8), .s_q(sq8), .c_q(cq8), .out_valid(ov8),
    .carry_cnt(cnt8), .clr_cnt(clr8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {s_q, c_q} for each accepted WIDTH=8 input
  logic [15:0] sb_q[$];

  initial begin
    logic [15:0] exp_pair;
    logic [7:0]  hold_s, hold_c;
    logic        exp_ov;
    logic [15:0] exp_cnt8;
    logic [1:0]  ab;

    rst_n = 1'b0;
    a1 = 0; b1 = 0; iv1 = 0; clr1 = 0;
    a4 = 0; b4 = 0; iv4 = 0; clr4 = 0;
    a8 = 0; b8 = 0; iv8 = 0; clr8 = 0;
    #3;
    chk("rst_sq",  64'(sq1),  64'(0));
    chk("rst_cq",  64'(cq1),  64'(0));
    chk("rst_ov",  64'(ov1),  64'(0));
    chk("rst_cnt", 64'(cnt1), 64'(0));

    // Combinational truth table, while still held in reset
    for (int k = 0; k < 4; k++) begin
      ab = 2'(k);
      a1 = ab[1]; b1 = ab[0];
      #1;
      chk("tt_s", 64'(s1), 64'(ab[1] ^ ab[0]));
      chk("tt_c", 64'(c1), 64'(ab[1] & ab[0]));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Carry input captured with one-cycle latency
    a1 = 1; b1 = 1; iv1 = 1;
    tick();
    chk("cap_sq",  64'(sq1),  64'(0));
    chk("cap_cq",  64'(cq1),  64'(1));
    chk("cap_ov",  64'(ov1),  64'(1));
    chk("cap_cnt", 64'(cnt1), 64'(1));
    @(negedge clk);
    iv1 = 0; a1 = 0; b1 = 1;
    tick();
    chk("hold_sq",  64'(sq1),  64'(0));
    chk("hold_cq",  64'(cq1),  64'(1));
    chk("hold_ov",  64'(ov1),  64'(0));
    chk("hold_cnt", 64'(cnt1), 64'(1));

    // Load s_q=1 then assert reset mid-cycle
    @(negedge clk);
    a1 = 1; b1 = 0; iv1 = 1;
    tick();
    chk("load_sq", 64'(sq1), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sq",  64'(sq1),  64'(0));
    chk("arst_cq",  64'(cq1),  64'(0));
    chk("arst_ov",  64'(ov1),  64'(0));
    chk("arst_cnt", 64'(cnt1), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; iv1 = 0;

    // WIDTH=4 lanes
    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1;
    #1;
    chk("w4_s", 64'(s4), 64'(4'b0110));
    chk("w4_c", 64'(c4), 64'(4'b1000));
    tick();
    chk("w4_sq",  64'(sq4),  64'(4'b0110));
    chk("w4_cq",  64'(cq4),  64'(4'b1000));
    chk("w4_cnt", 64'(cnt4), 64'(1));

    // Saturation of 2-bit counter, then clear beats increment
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    chk("sat_cnt", 64'(cnt4), 64'(3));
    @(negedge clk);
    clr4 = 1;
    tick();
    chk("clr_cnt", 64'(cnt4), 64'(0));
    chk("clr_sq",  64'(sq4),  64'(0));
    chk("clr_cq",  64'(cq4),  64'(4'b1111));
    chk("clr_ov",  64'(ov4),  64'(1));
    @(negedge clk);
    clr4 = 0; iv4 = 0;

    // Random WIDTH=8 traffic against scoreboard
    hold_s = '0; hold_c = '0; exp_cnt8 = '0;
    for (int k = 0; k < 1000; k++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      iv8 = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_s", 64'(s8), 64'(a8 ^ b8));
      chk("rnd_c", 64'(c8), 64'(a8 & b8));
      exp_ov = iv8;
      if (iv8) begin
        sb_q.push_back({a8 ^ b8, a8 & b8});
        if ((a8 & b8) != 8'h00) exp_cnt8++;
      end
      tick();
      chk("rnd_ov", 64'(ov8), 64'(exp_ov));
      if (ov8) begin
        if (sb_q.size() == 0) begin
          chk("rnd_sb_empty", 64'(1), 64'(0));
        end else begin
          exp_pair = sb_q.pop_front();
          hold_s = exp_pair[15:8];
          hold_c = exp_pair[7:0];
        end
      end
      chk("rnd_sq", 64'(sq8), 64'(hold_s));
      chk("rnd_cq", 64'(cq8), 64'(hold_c));
      @(negedge clk);
    end
    iv8 = 0;
    chk("rnd_cnt",   64'(cnt8),        64'(exp_cnt8));
    chk("rnd_drain", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
